// File: rtl/sr_noc_inject_q.sv
// NoC injection queue: buffers memory-controller packet pulses and serializes each into header + payload flits.
// Optional checksum flit is enabled with `define SR_NOC_INJ_CHECKSUM_EN.
module sr_noc_inject_q #(
  parameter int NODE_ID         = 0,
  parameter int NODE_COUNT      = 8,
  parameter int PACKET_ID_WIDTH = 5,
  parameter int FLIT_WIDTH      = 32,
  parameter int DEPTH           = 4,
  localparam int DW             = (NODE_COUNT > 1) ? $clog2(NODE_COUNT) : 1,
  localparam int CW             = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [67:0]                packetIn,
  input  logic [DW-1:0]              nodeDest,
  input  logic [PACKET_ID_WIDTH-1:0] packetId,
  input  logic                       validIn,
  output logic [FLIT_WIDTH-1:0]      flitOut,
  output logic                       flitValid,
  input  logic                       flitReady,
  output logic                       flitLast,
  output logic [CW-1:0]              queueCount,
  output logic                       overflow,
  output logic [1:0]                 fsm_state
);

  localparam int PW   = 68;
  localparam int EW   = DW + PACKET_ID_WIDTH + PW;
  localparam int NP   = (PW + FLIT_WIDTH - 1) / FLIT_WIDTH;
  localparam int PADW = NP * FLIT_WIDTH;
  localparam int BW   = (NP > 1) ? $clog2(NP) : 1;
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [BW-1:0] LAST_BEAT = BW'(NP - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HEAD = 2'd1;
  localparam logic [1:0] S_BODY = 2'd2;
`ifdef SR_NOC_INJ_CHECKSUM_EN
  localparam logic [1:0] S_CSUM = 2'd3;
`endif

  // Valid/ready: a flit moves on any edge where flitValid && flitReady; while
  // flitValid is high and flitReady low, flitOut/flitLast are held unchanged.
  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [EW-1:0]   cur;
  logic [1:0]      state;
  logic [BW-1:0]   beat;
  logic [PADW-1:0] padded;
  logic            push, pop, xfer, last_beat, pkt_done;

  assign padded     = PADW'(cur[PW-1:0]);
  assign last_beat  = (beat == LAST_BEAT);
  assign xfer       = flitValid && flitReady;
  assign pkt_done   = xfer && flitLast;
  // Fullness is judged on the registered count, so a same-cycle pop cannot rescue a push.
  assign push       = validIn && (count != DEPTH_C);
  assign pop        = (count != '0) && ((state == S_IDLE) || pkt_done);
  assign queueCount = count;
  assign fsm_state  = state;

`ifdef SR_NOC_INJ_CHECKSUM_EN
  logic [FLIT_WIDTH-1:0] csum;
  always_comb begin
    csum = '0;
    for (int i = 0; i < NP; i++) csum = csum ^ padded[i*FLIT_WIDTH +: FLIT_WIDTH];
  end
`endif

  always_comb begin
    flitOut   = '0;
    flitValid = 1'b0;
    flitLast  = 1'b0;
    case (state)
      S_HEAD: begin
        flitValid                                = 1'b1;
        flitOut[DW-1:0]                          = cur[PW+PACKET_ID_WIDTH +: DW];
        flitOut[DW +: DW]                        = DW'(NODE_ID);
        flitOut[2*DW +: PACKET_ID_WIDTH]         = cur[PW +: PACKET_ID_WIDTH];
      end
      S_BODY: begin
        flitValid = 1'b1;
        flitOut   = padded[beat*FLIT_WIDTH +: FLIT_WIDTH];
`ifdef SR_NOC_INJ_CHECKSUM_EN
        flitLast  = 1'b0;
`else
        flitLast  = last_beat;
`endif
      end
`ifdef SR_NOC_INJ_CHECKSUM_EN
      S_CSUM: begin
        flitValid = 1'b1;
        flitOut   = csum;
        flitLast  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Storage array carries no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {nodeDest, packetId, packetIn};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      cur      <= '0;
      state    <= S_IDLE;
      beat     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (validIn && (count == DEPTH_C)) overflow <= 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (pop) begin
        cur    <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      case (state)
        S_IDLE: if (pop) state <= S_HEAD;
        S_HEAD: if (xfer) begin
          state <= S_BODY;
          beat  <= '0;
        end
        S_BODY: if (xfer) begin
          if (!last_beat) beat <= beat + 1'b1;
`ifdef SR_NOC_INJ_CHECKSUM_EN
          else state <= S_CSUM;
`else
          else state <= pop ? S_HEAD : S_IDLE;
`endif
        end
`ifdef SR_NOC_INJ_CHECKSUM_EN
        S_CSUM: if (xfer) state <= pop ? S_HEAD : S_IDLE;
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_noc_inject_q.sv
// Directed testbench for sr_noc_inject_q (NODE_ID = 2, DEPTH = 4, FLIT_WIDTH = 32).
module tb_sr_noc_inject_q;

`ifdef SR_NOC_INJ_CHECKSUM_EN
  localparam int PKT_FLITS = 5;
`else
  localparam int PKT_FLITS = 4;
`endif
  localparam int NODE = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [67:0] packetIn;
  logic [2:0]  nodeDest;
  logic [4:0]  packetId;
  logic        validIn;
  logic [31:0] flitOut;
  logic        flitValid;
  logic        flitReady;
  logic        flitLast;
  logic [2:0]  queueCount;
  logic        overflow;
  logic [1:0]  fsm_state;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_f [5];
  logic [31:0] lit   [5];

  sr_noc_inject_q #(.NODE_ID(NODE), .NODE_COUNT(8), .PACKET_ID_WIDTH(5),
                    .FLIT_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .packetIn(packetIn), .nodeDest(nodeDest),
    .packetId(packetId), .validIn(validIn), .flitOut(flitOut),
    .flitValid(flitValid), .flitReady(flitReady), .flitLast(flitLast),
    .queueCount(queueCount), .overflow(overflow), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  // Reference model of the flit stream for one packet.
  task automatic build_exp(input logic [2:0] dest, input logic [4:0] pid, input logic [67:0] pkt);
    exp_f[0] = (32'(pid) << 6) | (32'(NODE) << 3) | 32'(dest);
    exp_f[1] = pkt[31:0];
    exp_f[2] = pkt[63:32];
    exp_f[3] = {28'h0, pkt[67:64]};
    exp_f[4] = exp_f[1] ^ exp_f[2] ^ exp_f[3];
  endtask

  function automatic logic [67:0] pkt_of(input int i);
    logic [67:0] p;
    p = {4'(i), 32'hC0DE_0000 | 32'(i), 32'h5A00_0000 + 32'(i)};
    return p;
  endfunction

  task automatic push_one(input logic [2:0] dest, input logic [4:0] pid, input logic [67:0] pkt);
    nodeDest = dest;
    packetId = pid;
    packetIn = pkt;
    validIn  = 1'b1;
    @(negedge clk);
    validIn  = 1'b0;
  endtask

  // Waits (bounded) for a transfer, returns the flit; called and returns at a negedge.
  task automatic get_flit(output logic [31:0] d, output logic l, output bit ok);
    ok = 1'b0;
    d  = '0;
    l  = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (flitValid && flitReady) begin
        d  = flitOut;
        l  = flitLast;
        ok = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1; validIn = 1'b0; flitReady = 1'b0;
    nodeDest = '0; packetId = '0; packetIn = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if (flitValid !== 1'b0 || flitOut !== 32'h0 || flitLast !== 1'b0) begin
      failures++;
      $display("FAIL reset_flit: valid=%b out=%h last=%b expected 0/0/0", flitValid, flitOut, flitLast);
    end
    checks++;
    if (queueCount !== 3'd0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_queue: count=%0d overflow=%b expected 0/0", queueCount, overflow);
    end
  endtask

  task automatic test_single;
    logic [31:0] d; logic l; bit ok;
    flitReady = 1'b1;
    push_one(3'd5, 5'd3, 68'hA_1234_5678_9ABC_DEF0);
    checks++;
    if (flitValid !== 1'b0) begin
      failures++;
      $display("FAIL single_lat1: flitValid=%b expected 0", flitValid);
    end
    @(negedge clk);
    checks++;
    if (flitValid !== 1'b1) begin
      failures++;
      $display("FAIL single_lat2: flitValid=%b expected 1", flitValid);
    end
    for (int k = 0; k < PKT_FLITS; k++) begin
      get_flit(d, l, ok);
      checks++;
      if (!ok || d !== lit[k] || l !== (k == PKT_FLITS - 1)) begin
        failures++;
        $display("FAIL single_flit%0d: got %h last=%b ok=%b expected %h last=%b",
                 k, d, l, ok, lit[k], (k == PKT_FLITS - 1));
      end
    end
    checks++;
    if (flitValid !== 1'b0) begin
      failures++;
      $display("FAIL single_idle: flitValid=%b expected 0", flitValid);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] d; logic l; bit ok;
    flitReady = 1'b1;
    push_one(3'd5, 5'd3, 68'hA_1234_5678_9ABC_DEF0);
    get_flit(d, l, ok);
    checks++;
    if (!ok || d !== lit[0]) begin
      failures++;
      $display("FAIL bp_head: got %h ok=%b expected %h", d, ok, lit[0]);
    end
    flitReady = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (flitValid !== 1'b1 || flitOut !== 32'h9ABCDEF0 || flitLast !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold%0d: valid=%b out=%h last=%b expected 1/9abcdef0/0",
                 c, flitValid, flitOut, flitLast);
      end
    end
    flitReady = 1'b1;
    for (int k = 1; k < PKT_FLITS; k++) begin
      get_flit(d, l, ok);
      checks++;
      if (!ok || d !== lit[k] || l !== (k == PKT_FLITS - 1)) begin
        failures++;
        $display("FAIL bp_flit%0d: got %h last=%b ok=%b expected %h", k, d, l, ok, lit[k]);
      end
    end
  endtask

  task automatic test_burst;
    logic [31:0] d; logic l; bit ok;
    flitReady = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      nodeDest = 3'(i);
      packetId = 5'(i);
      packetIn = pkt_of(i);
      validIn  = 1'b1;
      @(negedge clk);
    end
    validIn = 1'b0;
    build_exp(3'd1, 5'd1, pkt_of(1));
    checks++;
    if (queueCount !== 3'd4 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL burst_full: count=%0d overflow=%b expected 4/1", queueCount, overflow);
    end
    checks++;
    if (flitValid !== 1'b1 || flitOut !== exp_f[0]) begin
      failures++;
      $display("FAIL burst_head1: valid=%b out=%h expected 1/%h", flitValid, flitOut, exp_f[0]);
    end
    flitReady = 1'b1;
    for (int p = 1; p <= 5; p++) begin
      build_exp(3'(p), 5'(p), pkt_of(p));
      for (int k = 0; k < PKT_FLITS; k++) begin
        get_flit(d, l, ok);
        checks++;
        if (!ok || d !== exp_f[k] || l !== (k == PKT_FLITS - 1)) begin
          failures++;
          $display("FAIL burst_p%0d_f%0d: got %h last=%b ok=%b expected %h", p, k, d, l, ok, exp_f[k]);
        end
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (flitValid !== 1'b0 || queueCount !== 3'd0 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL burst_drained: valid=%b count=%0d overflow=%b expected 0/0/1",
               flitValid, queueCount, overflow);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rec [20];
    logic        rl  [20];
    int run;
    flitReady = 1'b1;
    push_one(3'd1, 5'd7, pkt_of(11));
    push_one(3'd6, 5'd9, pkt_of(12));
    for (int w = 0; w < 10 && !flitValid; w++) @(negedge clk);
    run = 0;
    while (flitValid && run < 20) begin
      rec[run] = flitOut;
      rl[run]  = flitLast;
      run++;
      @(negedge clk);
    end
    checks++;
    if (run != 2 * PKT_FLITS) begin
      failures++;
      $display("FAIL b2b_run: got %0d valid cycles expected %0d", run, 2 * PKT_FLITS);
    end
    build_exp(3'd6, 5'd9, pkt_of(12));
    checks++;
    if (rl[PKT_FLITS-1] !== 1'b1 || rec[PKT_FLITS] !== exp_f[0]) begin
      failures++;
      $display("FAIL b2b_second_head: last=%b head=%h expected 1/%h", rl[PKT_FLITS-1], rec[PKT_FLITS], exp_f[0]);
    end
    checks++;
    if (rec[2*PKT_FLITS-1] !== exp_f[PKT_FLITS-1] || rl[2*PKT_FLITS-1] !== 1'b1) begin
      failures++;
      $display("FAIL b2b_tail: got %h last=%b expected %h/1", rec[2*PKT_FLITS-1], rl[2*PKT_FLITS-1], exp_f[PKT_FLITS-1]);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d; logic l; bit ok;
    flitReady = 1'b1;
    // Make overflow sticky-high first so the reset clearing it is observable.
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL rmid_pre_overflow: got %b expected 1", overflow);
    end
    push_one(3'd3, 5'd21, pkt_of(21));
    push_one(3'd4, 5'd22, pkt_of(22));
    get_flit(d, l, ok);
    get_flit(d, l, ok);
    checks++;
    if (fsm_state !== 2'd2 || flitOut !== pkt_of(21)[63:32]) begin
      failures++;
      $display("FAIL rmid_beat1: state=%0d out=%h expected 2/%h", fsm_state, flitOut, pkt_of(21)[63:32]);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (flitValid !== 1'b0 || queueCount !== 3'd0 || overflow !== 1'b0 || flitOut !== 32'h0) begin
      failures++;
      $display("FAIL rmid_after: valid=%b count=%0d overflow=%b out=%h expected 0/0/0/0",
               flitValid, queueCount, overflow, flitOut);
    end
    rst = 1'b0;
    build_exp(3'd2, 5'd30, pkt_of(30));
    push_one(3'd2, 5'd30, pkt_of(30));
    for (int k = 0; k < PKT_FLITS; k++) begin
      get_flit(d, l, ok);
      checks++;
      if (!ok || d !== exp_f[k] || l !== (k == PKT_FLITS - 1)) begin
        failures++;
        $display("FAIL rmid_new_f%0d: got %h last=%b ok=%b expected %h", k, d, l, ok, exp_f[k]);
      end
    end
    repeat (4) @(negedge clk);
    checks++;
    if (flitValid !== 1'b0) begin
      failures++;
      $display("FAIL rmid_no_stale: flitValid=%b expected 0", flitValid);
    end
  endtask

  initial begin
    lit[0] = 32'h000000D5;
    lit[1] = 32'h9ABCDEF0;
    lit[2] = 32'h12345678;
    lit[3] = 32'h0000000A;
    lit[4] = 32'h88888882;
    test_reset();
    test_single();
    test_backpressure();
    test_burst();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sr_noc_inject_q.md
Name: sr_noc_inject_q

Overview:
- Injection stage directly downstream of the node memory controller.
- Captures the controller's single-cycle packet pulses (packet, destination, packet id, valid; no backpressure) into a small FIFO.
- Serializes each entry into a header flit plus payload flits on a valid/ready link toward the NoC router input port.
- Absorbs bursts so no request or load reply is lost while the router stalls.

Parameters:
- NODE_ID, 0, this node's index; placed in the header source field.
- NODE_COUNT, 8, number of nodes; DW = $clog2(NODE_COUNT).
- PACKET_ID_WIDTH, 5, width of packet id.
- FLIT_WIDTH, 32, link flit width; must be >= 2*DW+PACKET_ID_WIDTH and >= 16.
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- packetIn  in  68  packet from memory controller: data[66:35], address[34:3], instr[2:0].
- nodeDest  in  DW  destination node.
- packetId  in  PACKET_ID_WIDTH  packet id.
- validIn  in  1  one-cycle push strobe; no ready returned.
- flitOut  out  FLIT_WIDTH  current flit.
- flitValid  out  1  flitOut valid.
- flitReady  in  1  router accepts flit.
- flitLast  out  1  current flit is final flit of packet.
- queueCount  out  $clog2(DEPTH+1)  occupied FIFO entries.
- overflow  out  1  sticky; a push was dropped.

Behaviour:
- Reset: one clock; reset is synchronous and active-high. On rst all outputs are 0 (flitOut, flitValid, flitLast, queueCount, overflow); FIFO pointers 0; FSM = IDLE. Reset mid-packet abandons the packet and discards FIFO contents.
- Entry format: {nodeDest, packetId, packetIn}.
- Push: validIn with queueCount < DEPTH writes at the tail on that edge.
- Overflow: validIn with queueCount == DEPTH drops the entry and sets overflow. Fullness uses the registered count, so a pop in the same cycle does not rescue the push. overflow clears only on rst.
- Header flit: bits [DW-1:0] = dest; [2*DW-1:DW] = NODE_ID; [2*DW+PACKET_ID_WIDTH-1:2*DW] = packetId; upper bits 0.
- Payload flits: NP = ceil(68/FLIT_WIDTH). The packet is zero-extended to NP*FLIT_WIDTH and sent LSB slice first. With FLIT_WIDTH = 32: NP = 3, 4 flits total.
- Transfer rule: a flit transfers on an edge where flitValid && flitReady. flitOut and flitLast hold stable while flitValid && !flitReady. flitValid never drops before transfer.
- FSM states:
  - IDLE: flitValid = 0. If queueCount != 0, pop the head into the shift register and go to HEAD.
  - HEAD: present the header flit. On transfer, go to BODY with beat = 0.
  - BODY: present payload slice [beat]; flitLast = (beat == NP-1). On a non-last transfer, beat++. On the last transfer: if the FIFO is non-empty, pop the next entry and go to HEAD with no bubble; else go to IDLE.
- Latency: validIn at edge N with an empty queue and IDLE FSM gives header flitValid = 1 in the cycle after edge N+1 (two cycles).
- Simultaneous push and pop: the count is unchanged; both take effect.
- Pointers wrap modulo DEPTH.
- queueCount excludes the entry held in the serializer.

Optional Feature:
- Macro: SR_NOC_INJ_CHECKSUM_EN.
- Defined: after the NP payload flits, one extra flit carries the XOR of all payload flits. flitLast asserts on the checksum flit only; the packet is NP+2 flits.
- Undefined: no checksum flit; flitLast on payload beat NP-1; packet is NP+1 flits.

Test Plan:
- Single packet: NODE_ID = 2, flitReady = 1. Push nodeDest = 5, packetId = 3, packetIn = 68'hA_1234_5678_9ABC_DEF0 → flits 0x000000D5, 0x9ABCDEF0, 0x12345678, 0x0000000A (flitLast on the last). Header flitValid appears 2 cycles after the push.
- Backpressure: same packet with flitReady low for 5 cycles during the second flit → flitOut holds 0x9ABCDEF0 with flitValid high. Resume gives an identical sequence with no duplicate or skipped flit.
- Burst/overflow: DEPTH = 4, flitReady = 0, 6 consecutive pushes → first entry in serializer, queueCount = 4, 6th dropped, overflow = 1. Drain emits 5 packets in push order with ids intact.
- Back-to-back: two queued packets, flitReady = 1 → 8 consecutive flitValid cycles, with the second header immediately after the first flitLast.
- Reset mid-packet: rst during BODY beat 1 → next cycle flitValid = 0, queueCount = 0, overflow = 0. A new push emits a clean header.
- Checksum (SR_NOC_INJ_CHECKSUM_EN): packet from the first scenario → 5th flit 0x88888882 with flitLast; the 4th flit has flitLast = 0.
